// File: rtl/srec_word_packer.sv
// Packs the SREC parser's byte stream into big-endian 32-bit words and queues them for memory.
// Optional macro SREC_PACKER_OVERLAP_CHK_EN adds a sticky overlapErr output for lane overwrites.
module srec_word_packer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [ADDR_W-1:0] inAddr,
  input  logic [7:0]        inByte,
  input  logic              flush,
  output logic              memWrite,
  input  logic              memReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memData,
  output logic [3:0]        memByteEn,
  output logic [1:0]        memAccessSize,
  output logic              packDone,
  output logic [15:0]       wordCount
`ifdef SREC_PACKER_OVERLAP_CHK_EN
  ,
  output logic              overlapErr
`endif
);

  localparam int unsigned TAG_W = ADDR_W - 2;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic [3:0]       be;
  } entry_t;

  state_e           state_q, state_d;
  logic [TAG_W-1:0] acc_tag_q, acc_tag_d;
  logic [31:0]      acc_data_q, acc_data_d;
  logic [3:0]       acc_mask_q, acc_mask_d;
  logic             pack_done_q, pack_done_d;
  logic [15:0]      word_count_q, word_count_d;
  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept, push, pop, fifo_full, tag_hit, tag_miss;
  logic [1:0]       in_lane;
  logic [3:0]       lane_oh, merged_mask;
  logic [31:0]      merged_data;
  logic [TAG_W-1:0] in_tag;
  entry_t           push_entry;

  assign in_lane   = inAddr[1:0];
  assign in_tag    = inAddr[ADDR_W-1:2];
  assign lane_oh   = 4'b1000 >> in_lane;
  assign fifo_full = (count_q == CNT_W'(DEPTH));
  assign inReady   = !fifo_full && (state_q != DRAIN);
  assign accept    = inValid && inReady;
  assign memWrite  = (count_q != '0);
  assign pop       = memWrite && memReady;
  assign tag_hit   = (acc_mask_q != 4'b0000) && (in_tag == acc_tag_q);
  assign tag_miss  = (acc_mask_q != 4'b0000) && (in_tag != acc_tag_q);

  // Accumulator merge, word push and packer state sequencing
  always_comb begin
    state_d     = state_q;
    acc_tag_d   = acc_tag_q;
    acc_data_d  = acc_data_q;
    acc_mask_d  = acc_mask_q;
    push        = 1'b0;
    push_entry  = '0;
    merged_data = tag_hit ? acc_data_q : 32'h0;
    merged_mask = (tag_hit ? acc_mask_q : 4'b0000) | lane_oh;
    merged_data[{~in_lane, 3'b000} +: 8] = inByte;

    if (accept) begin
      if (tag_miss) begin
        push       = 1'b1;
        push_entry = '{tag: acc_tag_q, data: acc_data_q, be: acc_mask_q};
      end
      acc_tag_d  = in_tag;
      acc_data_d = merged_data;
      acc_mask_d = merged_mask;
      if (merged_mask == 4'b1111) begin
        push       = 1'b1;
        push_entry = '{tag: in_tag, data: merged_data, be: merged_mask};
        acc_mask_d = 4'b0000;
      end
    end

    case (state_q)
      IDLE, ACCUM: begin
        if (flush) begin
          state_d = DRAIN;
        end else if (accept) begin
          state_d = (acc_mask_d == 4'b0000) ? IDLE : ACCUM;
        end
      end
      DRAIN: begin
        if (acc_mask_q != 4'b0000) begin
          if (!fifo_full) begin
            push       = 1'b1;
            push_entry = '{tag: acc_tag_q, data: acc_data_q, be: acc_mask_q};
            acc_mask_d = 4'b0000;
          end
        end else if (count_q == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = accept ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase

    pack_done_d = (state_d == DONE);
  end

  // FIFO pointers, occupancy and the saturating accepted-word counter
  always_comb begin
    wr_ptr_d     = push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d     = pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d      = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
    word_count_d = (pop && word_count_q != 16'hFFFF) ? 16'(word_count_q + 16'd1) : word_count_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      acc_tag_q    <= '0;
      acc_data_q   <= '0;
      acc_mask_q   <= '0;
      pack_done_q  <= 1'b0;
      word_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      acc_tag_q    <= acc_tag_d;
      acc_data_q   <= acc_data_d;
      acc_mask_q   <= acc_mask_d;
      pack_done_q  <= pack_done_d;
      word_count_q <= word_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (push) fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  assign memAddr       = {fifo_q[rd_ptr_q].tag, 2'b00};
  assign memData       = fifo_q[rd_ptr_q].data;
  assign memByteEn     = fifo_q[rd_ptr_q].be;
  assign memAccessSize = 2'b10;
  assign packDone      = pack_done_q;
  assign wordCount     = word_count_q;

`ifdef SREC_PACKER_OVERLAP_CHK_EN
  logic overlap_q, overlap_d;

  // Sticky flag: an accepted byte landed on a lane the current word already holds
  always_comb begin
    overlap_d = overlap_q;
    if (accept && tag_hit && ((acc_mask_q & lane_oh) != 4'b0000)) overlap_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overlap_q <= 1'b0;
    else          overlap_q <= overlap_d;
  end

  assign overlapErr = overlap_q;
`endif

endmodule

// File: tb/tb_srec_word_packer.sv
// Bench for srec_word_packer: random byte streams checked against a word-level reference model.
module tb_srec_word_packer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        inValid, inReady, flush, memWrite, memReady, packDone;
  logic [31:0] inAddr, memAddr, memData;
  logic [7:0]  inByte;
  logic [3:0]  memByteEn;
  logic [1:0]  memAccessSize;
  logic [15:0] wordCount;
`ifdef SREC_PACKER_OVERLAP_CHK_EN
  logic        overlapErr;
`endif

  srec_word_packer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
    .inAddr(inAddr), .inByte(inByte), .flush(flush), .memWrite(memWrite),
    .memReady(memReady), .memAddr(memAddr), .memData(memData), .memByteEn(memByteEn),
    .memAccessSize(memAccessSize), .packDone(packDone), .wordCount(wordCount)
`ifdef SREC_PACKER_OVERLAP_CHK_EN
    , .overlapErr(overlapErr)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [29:0] m_tag;
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  int          exp_total;
  int          total = 0;
  int          bad = 0;
  bit          rand_ready_en = 0;

  // Record every word memory takes (handshake completes at the next rising edge)
  always @(negedge clock) begin
    if (reset_n && memWrite && memReady) obs_q.push_back('{memAddr, memData, memByteEn});
  end

  always @(posedge clock) begin
    if (rand_ready_en) begin
      #1 memReady = ($urandom_range(0, 2) != 0);
    end
  end

  function automatic logic [31:0] bm(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Reference model: a word is emitted when it fills, when a byte for another word arrives, or on flush
  function automatic void model_push();
    exp_q.push_back('{{m_tag, 2'b00}, m_data, m_mask});
    exp_total++;
    m_mask = 4'b0000;
    m_data = 32'h0;
  endfunction

  function automatic void model_byte(input logic [31:0] a, input logic [7:0] b);
    int lane = int'(a[1:0]);
    if (m_mask != 4'b0000 && a[31:2] != m_tag) model_push();
    m_tag = a[31:2];
    m_data[8*(3-lane) +: 8] = b;
    m_mask[3-lane] = 1'b1;
    if (m_mask == 4'b1111) model_push();
  endfunction

  function automatic void model_flush();
    if (m_mask != 4'b0000) model_push();
  endfunction

  function automatic void model_reset();
    m_mask = 4'b0000;
    m_data = 32'h0;
    m_tag = '0;
    exp_total = 0;
    exp_q.delete();
    obs_q.delete();
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    inValid = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // Present one byte and hold it until the block takes it
  task automatic send_byte(input logic [31:0] a, input logic [7:0] b);
    int n = 0;
    inValid = 1'b1;
    inAddr = a;
    inByte = b;
    @(negedge clock);
    while (!inReady && n < 500) begin
      n++;
      @(negedge clock);
    end
    if (!inReady) begin
      total++;
      bad++;
      $display("FAIL send_byte timeout: addr=%h inReady=%b, required 1", a, inReady);
    end else begin
      model_byte(a, b);
    end
    @(posedge clock);
    #1 inValid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    model_flush();
    @(posedge clock);
    #1 flush = 1'b0;
  endtask

  task automatic wait_pack_done();
    int n = 0;
    @(negedge clock);
    while (!packDone && n < 2000) begin
      n++;
      @(negedge clock);
    end
    if (!packDone) begin
      total++;
      bad++;
      $display("FAIL pack_done timeout: packDone=%b, required 1", packDone);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clock);
    while (memWrite && n < 2000) begin
      n++;
      @(negedge clock);
    end
    if (memWrite) begin
      total++;
      bad++;
      $display("FAIL drain timeout: memWrite=%b, required 0", memWrite);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    total++; if (memWrite !== 1'b0) begin bad++; $display("FAIL reset memWrite: got %b want 0", memWrite); end
    total++; if (memAddr !== 32'h0) begin bad++; $display("FAIL reset memAddr: got %h want 0", memAddr); end
    total++; if (memData !== 32'h0) begin bad++; $display("FAIL reset memData: got %h want 0", memData); end
    total++; if (memByteEn !== 4'b0) begin bad++; $display("FAIL reset memByteEn: got %b want 0", memByteEn); end
    total++; if (packDone !== 1'b0) begin bad++; $display("FAIL reset packDone: got %b want 0", packDone); end
    total++; if (wordCount !== 16'h0) begin bad++; $display("FAIL reset wordCount: got %h want 0", wordCount); end
    total++; if (inReady !== 1'b1) begin bad++; $display("FAIL reset inReady: got %b want 1", inReady); end
    total++; if (memAccessSize !== 2'b10) begin bad++; $display("FAIL reset memAccessSize: got %b want 10", memAccessSize); end
`ifdef SREC_PACKER_OVERLAP_CHK_EN
    total++; if (overlapErr !== 1'b0) begin bad++; $display("FAIL reset overlapErr: got %b want 0", overlapErr); end
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic test_full_word();
    logic [7:0] bytes [4];
    bytes[0] = 8'h27; bytes[1] = 8'hBD; bytes[2] = 8'hFF; bytes[3] = 8'hE0;
    memReady = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(32'h0040_0000 + 32'(i), bytes[i]);
    @(negedge clock);
    total++; if (memWrite !== 1'b1) begin bad++; $display("FAIL full_word latency: memWrite=%b want 1", memWrite); end
    @(posedge clock);
    #1;
    wait_drain();
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL full_word count: got %0d want 1", obs_q.size());
    end else if (obs_q[0].addr !== 32'h0040_0000 || obs_q[0].data !== 32'h27BD_FFE0 || obs_q[0].be !== 4'b1111) begin
      bad++; $display("FAIL full_word write: got %h/%h/%b want 00400000/27bdffe0/1111",
                      obs_q[0].addr, obs_q[0].data, obs_q[0].be);
    end
    total++; if (wordCount !== 16'd1) begin bad++; $display("FAIL full_word wordCount: got %0d want 1", wordCount); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_flush();
    int n = 0;
    int last_w = -1;
    memReady = 1'b1;
    send_byte(32'h0000_1002, 8'hAA);
    send_byte(32'h0000_1003, 8'hBB);
    pulse_flush();
    while (n < 100) begin
      @(negedge clock);
      if (memWrite) last_w = n;
      if (packDone) break;
      n++;
    end
    total++; if (packDone !== 1'b1) begin bad++; $display("FAIL flush packDone: got %b want 1", packDone); end
    total++; if (n - last_w != 2) begin bad++; $display("FAIL flush done_timing: got %0d want 2 negedges after last memWrite", n - last_w); end
    @(negedge clock);
    total++; if (packDone !== 1'b0) begin bad++; $display("FAIL flush pulse_width: packDone=%b want 0", packDone); end
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL flush count: got %0d want 1", obs_q.size());
    end else if (obs_q[0].addr !== 32'h1000 || obs_q[0].be !== 4'b0011 || obs_q[0].data[15:0] !== 16'hAABB) begin
      bad++; $display("FAIL flush write: got %h/%h/%b want 00001000/....aabb/0011",
                      obs_q[0].addr, obs_q[0].data, obs_q[0].be);
    end
    @(posedge clock);
    #1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_mismatch();
    memReady = 1'b1;
    send_byte(32'h0000_2000, 8'h11);
    send_byte(32'h0000_2008, 8'h22);
    wait_drain();
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL mismatch count: got %0d want 1", obs_q.size());
    end else if (obs_q[0].addr !== 32'h2000 || obs_q[0].be !== 4'b1000 || obs_q[0].data[31:24] !== 8'h11) begin
      bad++; $display("FAIL mismatch first: got %h/%h/%b want 00002000/11....../1000",
                      obs_q[0].addr, obs_q[0].data, obs_q[0].be);
    end
    pulse_flush();
    wait_pack_done();
    wait_drain();
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mismatch total: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 1; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].be !== exp_q[i].be ||
          (obs_q[i].data & bm(exp_q[i].be)) !== (exp_q[i].data & bm(exp_q[i].be))) begin
        bad++; $display("FAIL mismatch word%0d: got %h/%h/%b want %h/%h/%b", i, obs_q[i].addr, obs_q[i].data,
                        obs_q[i].be, exp_q[i].addr, exp_q[i].data, exp_q[i].be);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    logic [7:0]  b [24];
    base = 32'h0000_6000 + (32'($urandom_range(0, 255)) << 4);
    for (int i = 0; i < 24; i++) b[i] = 8'($urandom);
    memReady = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(base + 32'(i), b[i]);
    @(negedge clock);
    total++; if (inReady !== 1'b0) begin bad++; $display("FAIL backpressure inReady: got %b want 0", inReady); end
    total++; if (memWrite !== 1'b1) begin bad++; $display("FAIL backpressure memWrite: got %b want 1", memWrite); end
    @(posedge clock);
    #1;
    inValid = 1'b1;
    inAddr = base + 32'd16;
    inByte = b[16];
    repeat (3) @(negedge clock);
    total++;
    if (inReady !== 1'b0 || memAddr !== base) begin
      bad++; $display("FAIL backpressure hold: inReady=%b memAddr=%h want 0/%h", inReady, memAddr, base);
    end
    @(posedge clock);
    #1 memReady = 1'b1;
    for (int i = 16; i < 24; i++) send_byte(base + 32'(i), b[i]);
    wait_drain();
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL backpressure count: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].be !== exp_q[i].be || obs_q[i].data !== exp_q[i].data) begin
        bad++; $display("FAIL backpressure word%0d: got %h/%h/%b want %h/%h/%b", i, obs_q[i].addr, obs_q[i].data,
                        obs_q[i].be, exp_q[i].addr, exp_q[i].data, exp_q[i].be);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    memReady = 1'b1;
    send_byte(32'h0000_3100, 8'h5A);
    send_byte(32'h0000_3101, 8'hA5);
    do_reset();
    memReady = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(32'h0000_3000 + 32'(i), 8'($urandom));
    wait_drain();
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL reset_mid count: got %0d want 1", obs_q.size());
    end else if (obs_q[0].addr !== 32'h3000 || obs_q[0].be !== 4'b1111 || obs_q[0].data !== exp_q[0].data) begin
      bad++; $display("FAIL reset_mid write: got %h/%h/%b want 00003000/%h/1111",
                      obs_q[0].addr, obs_q[0].data, obs_q[0].be, exp_q[0].data);
    end
    total++; if (wordCount !== 16'd1) begin bad++; $display("FAIL reset_mid wordCount: got %0d want 1", wordCount); end
    exp_q.delete();
    obs_q.delete();
  endtask

`ifdef SREC_PACKER_OVERLAP_CHK_EN
  task automatic test_overlap();
    memReady = 1'b0;
    send_byte(32'h0000_4000, 8'h01);
    @(negedge clock);
    total++; if (overlapErr !== 1'b0) begin bad++; $display("FAIL overlap early: got %b want 0", overlapErr); end
    @(posedge clock);
    #1;
    send_byte(32'h0000_4000, 8'h02);
    for (int i = 1; i < 4; i++) send_byte(32'h0000_4000 + 32'(i), 8'(i));
    @(negedge clock);
    total++; if (overlapErr !== 1'b1) begin bad++; $display("FAIL overlap flag: got %b want 1", overlapErr); end
    total++;
    if (memWrite !== 1'b1 || memData[31:24] !== 8'h02) begin
      bad++; $display("FAIL overlap data: memWrite=%b byte0=%h want 1/02", memWrite, memData[31:24]);
    end
    @(posedge clock);
    #1 memReady = 1'b1;
    wait_drain();
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  task automatic test_random();
    logic [31:0] a;
    a = 32'h0001_0000;
    rand_ready_en = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 7) a = a + 32'd1;
      else a = 32'h0001_0000 + 32'($urandom_range(0, 31));
      send_byte(a, 8'($urandom));
    end
    pulse_flush();
    wait_pack_done();
    rand_ready_en = 0;
    @(posedge clock);
    #2 memReady = 1'b1;
    wait_drain();
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].be !== exp_q[i].be ||
          (obs_q[i].data & bm(exp_q[i].be)) !== (exp_q[i].data & bm(exp_q[i].be))) begin
        bad++; $display("FAIL random word%0d: got %h/%h/%b want %h/%h/%b", i, obs_q[i].addr, obs_q[i].data,
                        obs_q[i].be, exp_q[i].addr, exp_q[i].data, exp_q[i].be);
      end
    end
    total++; if (wordCount !== 16'(exp_total)) begin bad++; $display("FAIL random wordCount: got %0d want %0d", wordCount, exp_total); end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    inValid = 1'b0;
    inAddr = 32'h0;
    inByte = 8'h0;
    flush = 1'b0;
    memReady = 1'b0;
    test_reset();
    test_full_word();
    test_flush();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
`ifdef SREC_PACKER_OVERLAP_CHK_EN
    test_overlap();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/srec_word_packer.md
Name: srec_word_packer

Overview:
- Sits directly downstream of the SREC parser.
- Consumes the parser's byte-serial stream (address, byte) and packs bytes that share a word into big-endian 32-bit words with lane enables.
- Buffers packed words in a small FIFO and drains them to the main memory write port with a valid/ready handshake.
- Lets memory preload run at word granularity instead of one byte write per clock.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- ADDR_W, 32, byte-address width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- inValid  in  1  byte presented this cycle
- inReady  out  1  block can accept a byte this cycle
- inAddr  in  ADDR_W  byte address of inByte
- inByte  in  8  data byte
- flush  in  1  end-of-stream pulse (parser done); forces out the partial word
- memWrite  out  1  FIFO head valid for memory
- memReady  in  1  memory accepts head this cycle
- memAddr  out  ADDR_W  word-aligned address (bits [1:0]=0)
- memData  out  32  packed word, lane 0 in bits [31:24]
- memByteEn  out  4  lane enables, bit3=lane0 ... bit0=lane3
- memAccessSize  out  2  constant 2'b10 (word)
- packDone  out  1  one-cycle pulse when flush completes and FIFO is empty
- wordCount  out  16  words accepted by memory since reset, saturating at 16'hFFFF

Behaviour:
- Reset (async, reset_n=0):
  - Accumulator is empty, mask=0, FIFO is empty, state=IDLE.
  - Outputs: memWrite=0, memAddr=0, memData=0, memByteEn=0, packDone=0, wordCount=0, inReady=1, memAccessSize=2'b10.
  - Asserting reset mid-operation discards all pending bytes and words.
- Byte accept: inValid & inReady at a rising edge. Lane = inAddr[1:0]. Word tag = inAddr[ADDR_W-1:2].
- inReady = !fifoFull && state!=DRAIN.
- Accumulator rules on an accepted byte:
  - Empty: load the tag; set the byte in its lane; mask = that lane only.
  - Tag match: merge; a repeat lane overwrites the byte (last wins).
  - Tag mismatch: in the same cycle, push the old accumulator to the FIFO and load the new byte as a fresh accumulator. inReady already guarantees FIFO space.
  - When mask becomes 4'b1111 after a merge: push the word to the FIFO on that edge; the accumulator becomes empty.
- FIFO:
  - Push at most 1 entry per cycle; pop when memWrite & memReady.
  - A push and pop in the same cycle are both performed; occupancy is unchanged.
  - Full when occupancy == DEPTH. Pointers wrap modulo DEPTH.
  - Memory outputs are driven from the FIFO head. memWrite = FIFO not empty.
  - Head outputs are stable while memWrite=1 and memReady=0.
- States:
  - IDLE: accumulator empty. An accepted byte -> ACCUM. flush -> DRAIN.
  - ACCUM: accumulator holds data. Stays in ACCUM on merges and mismatch reloads. Goes to IDLE on a full-word push with no new byte. flush -> DRAIN.
  - DRAIN: on entry, push the partial accumulator if mask!=0 (wait for a free FIFO slot if full). Wait until the FIFO is empty -> DONE.
  - DONE: packDone=1 for exactly one cycle -> IDLE.
- flush in the same cycle as an accepted byte: the byte is merged/pushed first, then DRAIN is entered with the resulting accumulator.
- flush while in DRAIN or DONE is ignored.
- wordCount increments on every pop.
- Latency: a full word reaches memWrite 1 cycle after the 4th byte is accepted, when the FIFO was empty.

Optional Feature:
- Macro: SREC_PACKER_OVERLAP_CHK_EN.
- Defined: adds output overlapErr (1 bit, reset 0).
  - Sticky set when an accepted byte hits a lane already set in the current accumulator mask.
  - Cleared only by reset. The data still overwrites (last wins).
- Undefined: port and logic are absent; overwrites are silent.

Test Plan:
- Bytes 0x27,0xBD,0xFF,0xE0 at 0x00400000..03, memReady=1 -> one write: memAddr=0x00400000, memData=0x27BDFFE0, memByteEn=4'b1111, wordCount=1.
- Bytes 0xAA at 0x1002, 0xBB at 0x1003, then flush -> write memAddr=0x1000, memData[15:0]=0xAABB, memByteEn=4'b0011; packDone pulses 1 cycle after the FIFO empties.
- Byte 0x11 at 0x2000, then 0x22 at 0x2008 -> first write 0x2000, memByteEn=4'b1000; accumulator holds 0x2008 lane 0.
- memReady=0 while streaming 24 consecutive bytes -> 4 words buffered, inReady=0. Hold inValid and release memReady -> 6 words in address order, none lost or duplicated.
- Assert reset_n=0 mid-word, then release, then send bytes at 0x3000..03 -> only the 0x3000 word is written; wordCount=1.
- With SREC_PACKER_OVERLAP_CHK_EN: bytes 0x01 then 0x02 at 0x4000, then 0x4001..03 -> overlapErr=1; memData[31:24]=0x02.
